// File: rtl/axi_lite_pix_fifo_slv.sv
// AXI4-Lite register front end for a pixel FIFO with a fill-threshold level interrupt.
// Optional: define AXI_SLV_ERR_RESP_EN to answer unmapped/read-only/empty accesses with SLVERR.
module axi_lite_pix_fifo_slv #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 512,
    parameter int ADDR_W     = 4,
    parameter int THRESH_RST = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pix_valid,
    input  logic [DATA_W-1:0] i_pix_data,
    input  logic [ADDR_W-1:0] i_awaddr,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wstrb,
    input  logic              i_wvalid,
    output logic              o_wready,
    output logic [1:0]        o_bresp,
    output logic              o_bvalid,
    input  logic              i_bready,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic              i_arvalid,
    output logic              o_arready,
    output logic [31:0]       o_rdata,
    output logic [1:0]        o_rresp,
    output logic              o_rvalid,
    input  logic              i_rready,
    output logic              o_interrupt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_SLV_ERR_RESP_EN
    localparam logic [1:0] RESP_ERR = RESP_SLVERR;
`else
    localparam logic [1:0] RESP_ERR = RESP_OKAY;
`endif
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_INT_CLR = 2'd2;
    localparam logic [1:0] REG_THRESH  = 2'd3;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    wr_state_t         wr_state_q, wr_state_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              wr_commit;

    rd_state_t         rd_state_q, rd_state_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [31:0]       csr_rdata_q, csr_rdata_d;
    logic              rsel_fifo_q, rsel_fifo_d;
    logic              pop;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] fifo_rd_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d, int_pend_q, int_pend_d;
    logic [15:0]       thresh_q, thresh_d;
    logic              push, empty, full;
    logic [31:0]       status_word;

    logic aw_fire, w_fire, ar_fire;
    assign aw_fire = awready_q && i_awvalid;
    assign w_fire  = wready_q && i_wvalid;
    assign ar_fire = arready_q && i_arvalid;

    // AW and W are captured independently; the register update fires once both are held.
    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_commit  = 1'b0;
        unique case (wr_state_q)
            WR_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = i_awaddr;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = i_wdata;
                    wstrb_d  = i_wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    wr_commit  = 1'b1;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    wr_state_d = WR_RESP;
                end else begin
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            WR_RESP: begin
                if (i_bready) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = WR_IDLE;
                end
            end
        endcase
    end

    logic       wr_unmapped, wr_err, int_clr_hit, clr_int, clr_ovf, thresh_we;
    logic [1:0] wr_word;
    assign wr_word     = awaddr_d[3:2];
    assign wr_unmapped = |(awaddr_d >> 4);
    assign wr_err      = wr_unmapped || (wr_word == REG_DATA) || (wr_word == REG_STATUS);
    assign int_clr_hit = wr_commit && !wr_unmapped && (wr_word == REG_INT_CLR) && wstrb_d[0];
    assign clr_int     = int_clr_hit && wdata_d[0];
    assign clr_ovf     = int_clr_hit && wdata_d[1];
    assign thresh_we   = wr_commit && !wr_unmapped && (wr_word == REG_THRESH);
    assign bresp_d     = wr_commit ? (wr_err ? RESP_ERR : RESP_OKAY) : bresp_q;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_thresh_byte
        assign thresh_d[gi*8 +: 8] = (thresh_we && wstrb_d[gi]) ? wdata_d[gi*8 +: 8]
                                                                  : thresh_q[gi*8 +: 8];
    end

    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign status_word = {12'h0, int_pend_q, ovf_q, full, empty, 16'(count_q)};

    // DATA reads pop in the handshake cycle; the popped word is selected onto RDATA afterwards.
    always_comb begin
        rd_state_d  = rd_state_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        csr_rdata_d = csr_rdata_q;
        rsel_fifo_d = rsel_fifo_q;
        pop         = 1'b0;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (ar_fire) begin
                    rvalid_d    = 1'b1;
                    arready_d   = 1'b0;
                    rd_state_d  = RD_DATA;
                    csr_rdata_d = '0;
                    rresp_d     = RESP_OKAY;
                    rsel_fifo_d = 1'b0;
                    if (|(i_araddr >> 4)) begin
                        rresp_d = RESP_ERR;
                    end else begin
                        unique case (i_araddr[3:2])
                            REG_DATA: begin
                                if (!empty) begin
                                    pop         = 1'b1;
                                    rsel_fifo_d = 1'b1;
                                end else begin
                                    rresp_d = RESP_ERR;
                                end
                            end
                            REG_STATUS:  csr_rdata_d = status_word;
                            REG_INT_CLR: rresp_d = RESP_ERR;
                            REG_THRESH:  csr_rdata_d = {16'h0, thresh_q};
                        endcase
                    end
                end else begin
                    arready_d = 1'b1;
                end
            end
            RD_DATA: begin
                if (i_rready) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = RD_IDLE;
                end
            end
        endcase
    end

    // A push into a full FIFO is dropped and flagged; an interrupt set beats a same-cycle clear.
    logic int_set;
    assign push       = i_pix_valid && !full;
    assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    assign int_set    = (thresh_q != '0) && (32'(count_q) < 32'(thresh_q))
                        && (32'(count_d) >= 32'(thresh_q));
    assign int_pend_d = int_set ? 1'b1 : (clr_int ? 1'b0 : int_pend_q);
    assign ovf_d      = (i_pix_valid && full) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_pix_data;
        end
        if (pop) begin
            fifo_rd_q <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q  <= WR_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rd_state_q  <= RD_IDLE;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rresp_q     <= RESP_OKAY;
            csr_rdata_q <= '0;
            rsel_fifo_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            int_pend_q  <= 1'b0;
            thresh_q    <= 16'(THRESH_RST);
        end else begin
            wr_state_q  <= wr_state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rd_state_q  <= rd_state_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            csr_rdata_q <= csr_rdata_d;
            rsel_fifo_q <= rsel_fifo_d;
            wr_ptr_q    <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q    <= rd_ptr_q + PTR_W'(pop);
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            int_pend_q  <= int_pend_d;
            thresh_q    <= thresh_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{awaddr_d[1:0], wdata_d[31:16], wstrb_d[3:2], i_araddr[1:0]};

    assign o_awready   = awready_q;
    assign o_wready    = wready_q;
    assign o_bvalid    = bvalid_q;
    assign o_bresp     = bresp_q;
    assign o_arready   = arready_q;
    assign o_rvalid    = rvalid_q;
    assign o_rresp     = rresp_q;
    assign o_rdata     = rsel_fifo_q ? 32'(fifo_rd_q) : csr_rdata_q;
    assign o_interrupt = int_pend_q;
endmodule

// File: tb/tb_axi_lite_pix_fifo_slv.sv
// Randomised self-checking bench for axi_lite_pix_fifo_slv against a queue-based register model.
module tb_axi_lite_pix_fifo_slv;
    localparam int DATA_W = 16, DEPTH = 512, ADDR_W = 4, THRESH_RST = 256;
`ifdef AXI_SLV_ERR_RESP_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    logic clk, rst;
    logic i_pix_valid;
    logic [DATA_W-1:0] i_pix_data;
    logic [ADDR_W-1:0] i_awaddr, i_araddr;
    logic i_awvalid, o_awready, i_wvalid, o_wready, o_bvalid, i_bready;
    logic [31:0] i_wdata, o_rdata;
    logic [3:0] i_wstrb;
    logic [1:0] o_bresp, o_rresp;
    logic i_arvalid, o_arready, o_rvalid, i_rready, o_interrupt;

    axi_lite_pix_fifo_slv #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                            .THRESH_RST(THRESH_RST)) dut (
        .clk(clk), .rst(rst), .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data),
        .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_interrupt(o_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model: FIFO contents as a queue, flags as bits, expected responses as queues.
    logic [15:0] m_q[$];
    logic [33:0] m_rexp[$];
    logic [1:0]  m_bexp[$];
    logic        m_ovf, m_int, m_aw_got, m_w_got;
    logic [15:0] m_thresh;
    logic [3:0]  m_awaddr, m_wstrb;
    logic [31:0] m_wdata;

    task automatic model_step();
        int old_cnt, new_cnt;
        logic set_int = 1'b0;
        logic set_ovf = 1'b0;
        logic [31:0] status;
        if (rst) begin
            m_q.delete(); m_rexp.delete(); m_bexp.delete();
            m_ovf = 0; m_int = 0; m_aw_got = 0; m_w_got = 0;
            m_thresh = 16'(THRESH_RST);
            return;
        end
        old_cnt = m_q.size();
        status = {12'h0, m_int, m_ovf, old_cnt == DEPTH, old_cnt == 0, 16'(old_cnt)};
        if (o_rvalid && i_rready && m_rexp.size() > 0) void'(m_rexp.pop_front());
        if (o_bvalid && i_bready && m_bexp.size() > 0) void'(m_bexp.pop_front());
        if (i_arvalid && o_arready) begin
            case (i_araddr[3:2])
                2'd0: if (old_cnt > 0) m_rexp.push_back({2'b00, 16'h0, m_q.pop_front()});
                      else m_rexp.push_back({ERR, 32'h0});
                2'd1: m_rexp.push_back({2'b00, status});
                2'd2: m_rexp.push_back({ERR, 32'h0});
                default: m_rexp.push_back({2'b00, 16'h0, m_thresh});
            endcase
        end
        if (i_pix_valid) begin
            if (old_cnt < DEPTH) m_q.push_back(i_pix_data);
            else set_ovf = 1'b1;
        end
        new_cnt = m_q.size();
        set_int = (m_thresh != 0) && (old_cnt < m_thresh) && (new_cnt >= m_thresh);
        if (i_awvalid && o_awready) begin m_aw_got = 1; m_awaddr = i_awaddr; end
        if (i_wvalid && o_wready) begin m_w_got = 1; m_wdata = i_wdata; m_wstrb = i_wstrb; end
        if (m_aw_got && m_w_got) begin
            m_aw_got = 0; m_w_got = 0;
            case (m_awaddr[3:2])
                2'd2: begin
                    m_bexp.push_back(2'b00);
                    if (m_wstrb[0] && m_wdata[0]) m_int = 0;
                    if (m_wstrb[0] && m_wdata[1]) m_ovf = 0;
                end
                2'd3: begin
                    m_bexp.push_back(2'b00);
                    if (m_wstrb[0]) m_thresh[7:0] = m_wdata[7:0];
                    if (m_wstrb[1]) m_thresh[15:8] = m_wdata[15:8];
                end
                default: m_bexp.push_back(ERR);
            endcase
        end
        if (set_int) m_int = 1;
        if (set_ovf) m_ovf = 1;
    endtask

    task automatic compare_step();
        chk("interrupt", o_interrupt, m_int);
        chk("rvalid", o_rvalid, m_rexp.size() > 0);
        if (o_rvalid && m_rexp.size() > 0) begin
            chk("rdata", o_rdata, m_rexp[0][31:0]);
            chk("rresp", o_rresp, m_rexp[0][33:32]);
        end
        chk("bvalid", o_bvalid, m_bexp.size() > 0);
        if (o_bvalid && m_bexp.size() > 0) chk("bresp", o_bresp, m_bexp[0]);
    endtask

    initial forever begin @(posedge clk); model_step(); end
    initial forever begin @(posedge clk); #1; compare_step(); end

    task automatic do_push(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); i_pix_valid = 1'b1; i_pix_data = base + 16'(i);
        end
        @(negedge clk); i_pix_valid = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, input int max_stall,
                            output logic [31:0] rd, output logic [1:0] rr);
        int n = 0;
        @(negedge clk); i_araddr = addr; i_arvalid = 1'b1;
        while (!o_arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("arready_timeout", 0, 1);
        @(negedge clk); i_arvalid = 1'b0;
        chk("read_latency", o_rvalid, 1);
        rd = o_rdata; rr = o_rresp;
        repeat ($urandom_range(max_stall, 0)) @(negedge clk);
        i_rready = 1'b1;
        @(negedge clk); i_rready = 1'b0;
    endtask

    task automatic send_aw(input logic [3:0] addr);
        int n = 0;
        @(negedge clk); i_awaddr = addr; i_awvalid = 1'b1;
        while (!o_awready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("awready_timeout", 0, 1);
        @(negedge clk); i_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        @(negedge clk); i_wdata = data; i_wstrb = strb; i_wvalid = 1'b1;
        while (!o_wready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("wready_timeout", 0, 1);
        @(negedge clk); i_wvalid = 1'b0;
    endtask

    // gap > 0: AW leads W by gap cycles; gap < 0: W leads AW.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int gap);
        int n = 0;
        fork
            begin
                if (gap < 0) begin
                    repeat (-gap) @(negedge clk);
                    chk("bvalid_before_both", o_bvalid, 0);
                end
                send_aw(addr);
            end
            begin
                if (gap > 0) begin
                    repeat (gap) @(negedge clk);
                    chk("bvalid_before_both", o_bvalid, 0);
                end
                send_w(data, strb);
            end
        join
        while (!o_bvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("bvalid_timeout", 0, 1);
        i_bready = 1'b1;
        @(negedge clk); i_bready = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  rr;
    int          k;
    bit          conc_done;

    initial begin
        #900000;
        chk("watchdog", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        rst = 1; i_pix_valid = 0; i_pix_data = 0; i_awaddr = 0; i_awvalid = 0;
        i_wdata = 0; i_wstrb = 0; i_wvalid = 0; i_bready = 0; i_araddr = 0;
        i_arvalid = 0; i_rready = 0;
        repeat (3) @(negedge clk);
        rst = 0;

        // reset in the middle of a pending read response and an address phase
        @(negedge clk); i_araddr = 4'h4; i_arvalid = 1;
        k = 0;
        while (!o_arready && k < 20) begin @(negedge clk); k++; end
        @(negedge clk); i_arvalid = 0; i_awaddr = 4'hC; i_awvalid = 1; rst = 1;
        repeat (3) @(negedge clk);
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_bvalid", o_bvalid, 0);
        chk("rst_ready", {o_awready, o_wready, o_arready}, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_resp", {o_bresp, o_rresp}, 0);
        i_awvalid = 0; rst = 0;
        axi_read(4'h4, 0, rd, rr); chk("status_after_reset", rd, 32'h0001_0000);
        axi_read(4'hC, 0, rd, rr); chk("thresh_after_reset", rd, 32'd256);

        // error-response paths
        axi_read(4'h0, 0, rd, rr); chk("empty_data_rdata", rd, 0); chk("empty_data_rresp", rr, ERR);
        axi_read(4'h8, 0, rd, rr); chk("int_clr_read_rresp", rr, ERR);
        axi_write(4'h4, 32'hFFFF, 4'hF, 0);

        // fill to threshold
        do_push(255, 16'h0000);
        chk("irq_before_256th", o_interrupt, 0);
        @(negedge clk); i_pix_valid = 1; i_pix_data = 16'h00FF;
        @(negedge clk); i_pix_valid = 0;
        chk("irq_after_256th", o_interrupt, 1);
        axi_read(4'h4, 0, rd, rr); chk("status_fill", rd, 32'h0008_0100);

        // clear and drain with stalls
        axi_write(4'h8, 32'h1, 4'hF, 2);
        chk("irq_cleared", o_interrupt, 0);
        for (int i = 0; i < 256; i++) begin
            axi_read(4'h0, 3, rd, rr);
            chk("drain_data", rd, i);
        end
        axi_read(4'h4, 0, rd, rr); chk("status_drained", rd, 32'h0001_0000);

        // overflow
        do_push(DEPTH + 3, 16'h1000);
        axi_read(4'h4, 0, rd, rr); chk("status_overflow", rd, 32'h000E_0200);
        axi_write(4'h8, 32'h2, 4'h1, -1);
        axi_read(4'h4, 0, rd, rr); chk("status_ovf_cleared", rd, 32'h000A_0200);
        for (int i = 0; i < DEPTH; i++) axi_read(4'h0, 0, rd, rr);

        // concurrent push and pop around a small fill level
        axi_write(4'hC, 32'd12, 4'h3, 0);
        axi_read(4'hC, 0, rd, rr); chk("thresh_written", rd, 32'd12);
        do_push(10, 16'h2000);
        k = 10; conc_done = 0;
        fork
            begin
                while (!conc_done) begin
                    @(negedge clk);
                    i_pix_valid = ($urandom_range(2, 0) == 0);
                    i_pix_data = 16'h2000 + 16'(k);
                    if (i_pix_valid) k++;
                end
                @(negedge clk); i_pix_valid = 0;
            end
            begin
                for (int i = 0; i < 30; i++) axi_read(4'h0, 0, rd, rr);
                conc_done = 1;
            end
        join

        // randomized mixed traffic
        fork
            begin
                for (int i = 0; i < 600; i++) begin
                    @(negedge clk);
                    i_pix_valid = $urandom_range(1, 0) == 1;
                    i_pix_data = 16'($urandom);
                end
                @(negedge clk); i_pix_valid = 0;
            end
            for (int i = 0; i < 60; i++)
                axi_read({2'($urandom_range(3, 0)), 2'b00}, 3, rd, rr);
            for (int i = 0; i < 12; i++) begin
                axi_write({2'($urandom_range(3, 0)), 2'b00}, $urandom_range(320, 0),
                          4'($urandom), int'($urandom_range(4, 0)) - 2);
                repeat ($urandom_range(20, 0)) @(negedge clk);
            end
        join

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
